// File: rtl/alu_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_frame_ctrl_if
// Brief   : RX/TX FIFO handshake and ALU operand/result bundle for alu_frame_ctrl.
// Rev     : 1.0
// ============================================================================
interface alu_frame_ctrl_if #(
    parameter int BUS_SIZE = 8,
    parameter int OP_W     = 6
);
    logic                rx_empty;
    logic [BUS_SIZE-1:0] r_data;
    logic                rd_uart;
    logic                tx_full;
    logic [BUS_SIZE-1:0] w_data;
    logic                wr_uart;
    logic [BUS_SIZE-1:0] op_a;
    logic [BUS_SIZE-1:0] op_b;
    logic [OP_W-1:0]     op_code;
    logic [BUS_SIZE-1:0] alu_result;

    modport master (
        input  rx_empty, r_data, tx_full, alu_result,
        output rd_uart, w_data, wr_uart, op_a, op_b, op_code
    );

    modport slave (
        output rx_empty, r_data, tx_full, alu_result,
        input  rd_uart, w_data, wr_uart, op_a, op_b, op_code
    );
endinterface

`default_nettype wire

// File: rtl/alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_frame_ctrl
// Brief   : Framed command sequencer: SOF/A/B/OP/CK from RX FIFO -> ALU ->
//           result and status bytes to TX FIFO, with inter-byte timeout.
// Rev     : 1.0
// ============================================================================
module alu_frame_ctrl #(
    parameter int                  BUS_SIZE = 8,
    parameter int                  OP_W     = 6,
    parameter logic [BUS_SIZE-1:0] SOF      = 8'hA5,
    parameter int                  TIMEOUT  = 100000,
    parameter int                  TMO_BITS = 17
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_frame_ctrl_if.master bus,
    output logic             busy,
    output logic [7:0]       err_count
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_A    = 4'd1,
        GET_B    = 4'd2,
        GET_OP   = 4'd3,
        GET_CK   = 4'd4,
        EXEC     = 4'd5,
        LATCH    = 4'd6,
        SEND_RES = 4'd7,
        SEND_STS = 4'd8
    } state_t;

    localparam logic [TMO_BITS-1:0] c_TMO_LAST = TMO_BITS'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BUS_SIZE-1:0] r_sa, r_sb, r_sop, r_ck;
    logic [BUS_SIZE-1:0] r_status, r_res, r_wd;
    logic [BUS_SIZE-1:0] r_op_a, r_op_b;
    logic [OP_W-1:0]     r_op_code;
    logic [TMO_BITS-1:0] r_tmo;
    logic [7:0]          r_err;

    logic                w_collect;
    logic                w_pop;
    logic                w_push;
    logic                w_err_inc;
    logic                w_tmo_hit;
    logic [BUS_SIZE-1:0] w_status;
    logic [BUS_SIZE-1:0] w_tx_byte;

    // Checksum error outranks the reserved-opcode-bits error.
    always_comb begin
        w_status = '0;
        if ((r_sa ^ r_sb ^ r_sop) != r_ck) begin
            w_status = BUS_SIZE'(1);
        end else if (r_sop[BUS_SIZE-1:OP_W] != '0) begin
            w_status = BUS_SIZE'(2);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err_inc   = 1'b0;
        w_tx_byte   = r_wd;
        w_collect   = (r_state == GET_A) || (r_state == GET_B) ||
                      (r_state == GET_OP) || (r_state == GET_CK);
        w_pop       = (w_collect || (r_state == IDLE)) && !bus.rx_empty && !reset;
        w_tmo_hit   = w_collect && !w_pop && (r_tmo == c_TMO_LAST);
        case (r_state)
            IDLE:     if (w_pop && (bus.r_data == SOF)) w_state_nxt = GET_A;
            GET_A:    if (w_pop) w_state_nxt = GET_B;
            GET_B:    if (w_pop) w_state_nxt = GET_OP;
            GET_OP:   if (w_pop) w_state_nxt = GET_CK;
            GET_CK:   if (w_pop) w_state_nxt = EXEC;
            EXEC: begin
                w_state_nxt = LATCH;
                w_err_inc   = (w_status != '0);
            end
            LATCH:    w_state_nxt = SEND_RES;
            SEND_RES: begin
                if (!bus.tx_full) begin
                    w_push      = 1'b1;
                    w_tx_byte   = r_res;
                    w_state_nxt = SEND_STS;
                end
            end
            SEND_STS: begin
                if (!bus.tx_full) begin
                    w_push      = 1'b1;
                    w_tx_byte   = r_status;
                    w_state_nxt = IDLE;
                end
            end
            default:  w_state_nxt = IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt = IDLE;
            w_err_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sa      <= '0;
            r_sb      <= '0;
            r_sop     <= '0;
            r_ck      <= '0;
            r_status  <= '0;
            r_res     <= '0;
            r_wd      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_tmo     <= '0;
            r_err     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= (w_collect && !w_pop && !w_tmo_hit) ? r_tmo + TMO_BITS'(1) : '0;
            if (w_pop) begin
                case (r_state)
                    GET_A:   r_sa  <= bus.r_data;
                    GET_B:   r_sb  <= bus.r_data;
                    GET_OP:  r_sop <= bus.r_data;
                    GET_CK:  r_ck  <= bus.r_data;
                    default: ;
                endcase
            end
            if (r_state == EXEC) begin
                r_status <= w_status;
                if (w_status == '0) begin
                    r_op_a    <= r_sa;
                    r_op_b    <= r_sb;
                    r_op_code <= r_sop[OP_W-1:0];
                end
            end
            // ALU inputs were loaded in EXEC, so alu_result is settled here.
            if (r_state == LATCH) begin
                r_res <= (r_status == '0) ? bus.alu_result : '0;
            end
            if (w_push) begin
                r_wd <= w_tx_byte;
            end
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign bus.rd_uart = w_pop;
    assign bus.wr_uart = w_push;
    assign bus.w_data  = w_tx_byte;
    assign bus.op_a    = r_op_a;
    assign bus.op_b    = r_op_b;
    assign bus.op_code = r_op_code;
    assign busy        = (r_state != IDLE);
    assign err_count   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_frame_ctrl
// Brief   : Table vectors, directed corner cases and random frame streams
//           checked against a byte-stream frame model.
// Rev     : 1.0
// ============================================================================
module tb_alu_frame_ctrl;

    localparam int         TMO  = 64;
    localparam logic [7:0] SOFB = 8'hA5;

    typedef struct {
        logic [7:0] a, b, op, ck, res, sts;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] err_count;

    alu_frame_ctrl_if #(.BUS_SIZE(8), .OP_W(6)) bif ();

    alu_frame_ctrl #(
        .BUS_SIZE(8), .OP_W(6), .SOF(SOFB), .TIMEOUT(TMO), .TMO_BITS(17)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_pops = 0;
    int         last_pop_cyc = 0;
    bit         pop_due = 1'b0;
    bit         rand_full = 1'b0;
    logic [7:0] last_w = 8'h00;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] exp_txq[$];
    int         tx_cyc[$];

    // Frame model state: m_cnt = -1 while hunting for SOF.
    int         m_cnt = -1;
    logic [7:0] m_buf[4];
    logic [7:0] m_opa = 8'h00;
    logic [7:0] m_opb = 8'h00;
    logic [5:0] m_opc = 6'h00;
    logic [7:0] m_err = 8'h00;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return 8'(sa >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign bif.alu_result = alu_f(bif.op_a, bif.op_b, bif.op_code);

    always @(negedge clk) begin
        cyc++;
        if (reset) last_w = 8'h00;
        if (bif.rd_uart) begin
            n_pops++;
            last_pop_cyc = cyc;
            pop_due = 1'b1;
            if (bif.rx_empty) begin
                n_err++;
                $display("FAIL rd_uart_empty: rd_uart=1 with rx_empty=1 at cycle %0d, required 0", cyc);
            end
        end
        if (bif.wr_uart) begin
            if (bif.tx_full) begin
                n_err++;
                $display("FAIL wr_uart_full: wr_uart=1 with tx_full=1 at cycle %0d, required 0", cyc);
            end
            txq.push_back(bif.w_data);
            tx_cyc.push_back(cyc);
            last_w = bif.w_data;
        end else if (bif.w_data !== last_w) begin
            n_err++;
            $display("FAIL w_data_hold: w_data=%0h at cycle %0d, required held %0h", bif.w_data, cyc, last_w);
        end
    end

    // Show-ahead RX FIFO: pop after the edge that consumed the head byte.
    always @(posedge clk) begin
        #1;
        if (pop_due) begin
            pop_due = 1'b0;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        bif.rx_empty = (rxq.size() == 0);
        bif.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic m_err_inc();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic m_frame();
        logic [7:0] sts;
        logic [7:0] res;
        if ((m_buf[0] ^ m_buf[1] ^ m_buf[2]) != m_buf[3]) sts = 8'h01;
        else if (m_buf[2] > 8'h3F)                        sts = 8'h02;
        else                                              sts = 8'h00;
        res = 8'h00;
        if (sts == 8'h00) begin
            m_opa = m_buf[0];
            m_opb = m_buf[1];
            m_opc = m_buf[2][5:0];
            res   = alu_f(m_opa, m_opb, m_opc);
        end else begin
            m_err_inc();
        end
        exp_txq.push_back(res);
        exp_txq.push_back(sts);
    endtask

    task automatic m_byte(input logic [7:0] v);
        if (m_cnt < 0) begin
            if (v == SOFB) m_cnt = 0;
        end else begin
            m_buf[m_cnt] = v;
            m_cnt++;
            if (m_cnt == 4) begin
                m_frame();
                m_cnt = -1;
            end
        end
    endtask

    task automatic m_reset();
        m_cnt = -1;
        m_opa = 8'h00;
        m_opb = 8'h00;
        m_opc = 6'h00;
        m_err = 8'h00;
        exp_txq.delete();
        txq.delete();
        tx_cyc.delete();
    endtask

    task automatic send(input logic [7:0] v);
        rxq.push_back(v);
        m_byte(v);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] ck);
        send(SOFB);
        send(a);
        send(b);
        send(op);
        send(ck);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while ((rxq.size() != 0 || busy) && n < budget) begin
            if (rand_full) bif.tx_full = ($urandom_range(0, 2) == 0);
            tick();
            n++;
        end
        if (rxq.size() != 0 || busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy=%0b rxq=%0d after %0d cycles, required idle", busy, rxq.size(), budget);
        end
        bif.tx_full = 1'b0;
        rand_full   = 1'b0;
    endtask

    task automatic wait_pops(input int n0, input int k, input int budget);
        int n;
        n = 0;
        while ((n_pops - n0) < k && n < budget) begin
            tick();
            n++;
        end
        chk("wait_pops", n_pops - n0, k);
    endtask

    task automatic check_resp(input string tag);
        chk({tag, ":tx_count"}, txq.size(), exp_txq.size());
        for (int i = 0; i < exp_txq.size() && i < txq.size(); i++)
            chk({tag, ":tx_byte"}, txq[i], exp_txq[i]);
        chk({tag, ":op_a"}, bif.op_a, m_opa);
        chk({tag, ":op_b"}, bif.op_b, m_opb);
        chk({tag, ":op_code"}, bif.op_code, m_opc);
        chk({tag, ":err_count"}, err_count, m_err);
        chk({tag, ":busy"}, busy, 0);
        txq.delete();
        exp_txq.delete();
        tx_cyc.delete();
    endtask

    task automatic rst_check(input string tag);
        chk({tag, ":op_a"}, bif.op_a, 0);
        chk({tag, ":op_b"}, bif.op_b, 0);
        chk({tag, ":op_code"}, bif.op_code, 0);
        chk({tag, ":err_count"}, err_count, 0);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":w_data"}, bif.w_data, 0);
        chk({tag, ":rd_uart"}, bif.rd_uart, 0);
        chk({tag, ":wr_uart"}, bif.wr_uart, 0);
    endtask

    initial begin
        vec_t       tab[10];
        logic [7:0] ops[8];
        logic [7:0] a, b, op, ck, g;
        int         n0, pc, dcyc, nf, n;

        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        tab[0] = '{8'h05, 8'h03, 8'h20, 8'h26, 8'h08, 8'h00};
        tab[1] = '{8'h05, 8'h03, 8'h20, 8'h27, 8'h00, 8'h01};
        tab[2] = '{8'h10, 8'h04, 8'h22, 8'h36, 8'h0C, 8'h00};
        tab[3] = '{8'hF0, 8'h3C, 8'h24, 8'hE8, 8'h30, 8'h00};
        tab[4] = '{8'hF0, 8'h0F, 8'h25, 8'hDA, 8'hFF, 8'h00};
        tab[5] = '{8'h12, 8'h34, 8'hC0, 8'hE6, 8'h00, 8'h02};
        tab[6] = '{8'hFF, 8'h01, 8'h20, 8'hDE, 8'h00, 8'h00};
        tab[7] = '{8'h80, 8'h02, 8'h03, 8'h81, 8'hE0, 8'h00};
        tab[8] = '{8'h55, 8'hAA, 8'h26, 8'hD9, 8'hFF, 8'h00};
        tab[9] = '{8'h12, 8'h34, 8'hC0, 8'hE7, 8'h00, 8'h01};

        reset       = 1'b1;
        bif.tx_full = 1'b0;
        repeat (3) tick();
        rst_check("reset");
        reset = 1'b0;
        tick();

        // Good ADD frame: pop count and best-case latency.
        n0 = n_pops;
        send_frame(8'h05, 8'h03, 8'h20, 8'h26);
        wait_idle(100);
        chk("add_pops", n_pops - n0, 5);
        if (tx_cyc.size() >= 2) begin
            chk("add_latency", tx_cyc[0] - last_pop_cyc, 3);
            chk("add_sts_gap", tx_cyc[1] - tx_cyc[0], 1);
        end else begin
            chk("add_tx_count", tx_cyc.size(), 2);
        end
        check_resp("add");

        for (int i = 0; i < 10; i++) begin
            send_frame(tab[i].a, tab[i].b, tab[i].op, tab[i].ck);
            wait_idle(100);
            if (txq.size() == 2) begin
                chk("tab_res", txq[0], tab[i].res);
                chk("tab_sts", txq[1], tab[i].sts);
            end else begin
                chk("tab_tx_count", txq.size(), 2);
            end
            check_resp("tab");
        end

        // Garbage before SOF is popped and dropped silently.
        n0 = n_pops;
        send(8'h11);
        send(8'h22);
        send_frame(8'h07, 8'h09, 8'h20, 8'h2E);
        wait_idle(100);
        chk("garbage_pops", n_pops - n0, 7);
        check_resp("garbage");

        // Inter-byte timeout after A5 05.
        n0 = n_pops;
        send(SOFB);
        send(8'h05);
        wait_pops(n0, 2, 50);
        pc = last_pop_cyc;
        n  = 0;
        while (busy && n < TMO + 20) begin
            tick();
            n++;
        end
        chk("tmo_delay", cyc - pc, TMO);
        m_cnt = -1;
        m_err_inc();
        check_resp("tmo");
        send_frame(8'h21, 8'h12, 8'h26, 8'h15);
        wait_idle(100);
        check_resp("post_tmo");

        // Backpressure: TX full for 20 cycles after the frame is taken.
        bif.tx_full = 1'b1;
        n0 = n_pops;
        send_frame(8'h0A, 8'h0B, 8'h25, 8'h24);
        wait_pops(n0, 5, 50);
        repeat (20) tick();
        chk("bp_no_push", txq.size(), 0);
        bif.tx_full = 1'b0;
        dcyc = cyc + 1;
        wait_idle(50);
        if (tx_cyc.size() >= 2) begin
            chk("bp_res_cycle", tx_cyc[0], dcyc);
            chk("bp_sts_cycle", tx_cyc[1], dcyc + 1);
        end else begin
            chk("bp_tx_count", tx_cyc.size(), 2);
        end
        check_resp("bp");

        // Reset during GET_B.
        n0 = n_pops;
        send(SOFB);
        send(8'h05);
        wait_pops(n0, 2, 50);
        tick();
        reset = 1'b1;
        #1;
        rst_check("rst_getb");
        m_reset();
        tick();
        reset = 1'b0;
        tick();
        send_frame(8'h21, 8'h12, 8'h26, 8'h15);
        wait_idle(100);
        check_resp("after_rst_getb");

        // Reset during SEND_STS, result byte already pushed.
        bif.tx_full = 1'b1;
        n0 = n_pops;
        send_frame(8'h05, 8'h03, 8'h20, 8'h26);
        wait_pops(n0, 5, 50);
        repeat (4) tick();
        bif.tx_full = 1'b0;
        tick();
        bif.tx_full = 1'b1;
        repeat (3) tick();
        chk("sts_stall_busy", busy, 1);
        chk("sts_partial_count", txq.size(), 1);
        if (txq.size() >= 1) chk("sts_partial_res", txq[0], 8'h08);
        reset = 1'b1;
        #1;
        rst_check("rst_sts");
        m_reset();
        bif.tx_full = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_sts_no_push", txq.size(), 0);
        send_frame(8'hF0, 8'h3C, 8'h24, 8'hE8);
        wait_idle(100);
        check_resp("after_rst_sts");

        // Random frame streams with random TX backpressure.
        for (int r = 0; r < 25; r++) begin
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                if ($urandom_range(0, 3) == 0) begin
                    g = 8'($urandom);
                    if (g == SOFB) g = 8'h5A;
                    send(g);
                end
                a  = 8'($urandom);
                b  = 8'($urandom);
                op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 8'($urandom);
                ck = a ^ b ^ op;
                if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
                send_frame(a, b, op, ck);
            end
            rand_full = 1'b1;
            wait_idle(400);
            check_resp("rand");
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send_frame(a, b, 8'h20, a ^ b ^ 8'h21);
        end
        wait_idle(260 * 12 + 100);
        chk("err_saturated", err_count, 8'hFF);
        check_resp("sat");
        send_frame(8'h10, 8'h04, 8'h22, 8'h36);
        wait_idle(100);
        check_resp("post_sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_frame_ctrl.md
Name: alu_frame_ctrl

Overview:
Framed-command sequencer between the UART core FIFOs and the combinational ALU.
- Hunts a start-of-frame byte, then collects operand A, operand B, opcode and an XOR checksum from the RX FIFO.
- Validates the frame, presents the operands to the ALU and samples the result.
- Returns a 2-byte response (result, status) through the TX FIFO.
- Aborts stalled frames on an inter-byte timeout and keeps a saturating error counter for debug.

Parameters:
BUS_SIZE, 8, data/operand width
OP_W, 6, ALU opcode width (BUS_SIZE-2)
SOF, 8'hA5, start-of-frame byte
TIMEOUT, 100000, max clk cycles between consecutive frame bytes (1 ms @ 100 MHz)
TMO_BITS, 17, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
rx_empty  in  1  RX FIFO empty; r_data valid when 0
r_data  in  BUS_SIZE  RX FIFO head (show-ahead)
rd_uart  out  1  1-cycle pop strobe; byte taken is r_data in that same cycle
tx_full  in  1  TX FIFO full
w_data  out  BUS_SIZE  byte to transmit, valid with wr_uart
wr_uart  out  1  1-cycle push strobe; asserted only when tx_full=0
op_a  out  BUS_SIZE  registered ALU operand A
op_b  out  BUS_SIZE  registered ALU operand B
op_code  out  OP_W  registered ALU opcode
alu_result  in  BUS_SIZE  combinational ALU result for op_a/op_b/op_code
busy  out  1  1 in any state other than IDLE
err_count  out  8  saturating count of checksum, opcode and timeout errors

Behaviour:
Reset (async, active-high):
- state=IDLE.
- op_a, op_b, op_code, w_data, err_count, timeout counter = 0.
- rd_uart, wr_uart, busy = 0.

FSM states: IDLE, GET_A, GET_B, GET_OP, GET_CK, EXEC, LATCH, SEND_RES, SEND_STS.

Byte intake (IDLE and GET_*):
- When rx_empty=0, assert rd_uart for exactly one cycle and capture r_data in that cycle.
- Never assert rd_uart while rx_empty=1.
- At most one pop per cycle. After a pop the FSM advances, so the next pop is no earlier than the following cycle.

State transitions:
- IDLE: pop every available byte. Byte==SOF -> GET_A. Any other byte is discarded silently (no error count).
- GET_A / GET_B / GET_OP: capture into shadow regs sa, sb, sop, then advance.
- GET_CK: capture ck -> EXEC.
- Timeout counter: cleared on every pop; increments each cycle in GET_* while no pop occurs.
  - On reaching TIMEOUT-1: drop the frame, err_count++ (saturate at 255), go to IDLE.
  - No response is sent for a timed-out frame.
- EXEC: compute the status byte.
  - 8'h01 if (sa^sb^sop)!=ck; checksum has priority over the opcode check.
  - else 8'h02 if sop[7:6]!=0.
  - else 8'h00.
  - Status 00: load op_a=sa, op_b=sb, op_code=sop[5:0].
  - Nonzero status: ALU registers are not updated, and err_count++ (saturating).
  - -> LATCH.
- LATCH: one cycle for the ALU to settle on the new registers.
  - res_reg = alu_result if status 00, else 8'h00.
  - -> SEND_RES.
- SEND_RES: wait while tx_full=1. In the first cycle with tx_full=0, drive wr_uart=1 and w_data=res_reg for one cycle -> SEND_STS.
- SEND_STS: same rule with w_data=status -> IDLE.

Timing and hold rules:
- Best-case latency, last RX pop (ck) to first wr_uart: 3 cycles (EXEC, LATCH, SEND_RES).
- w_data holds its last value when wr_uart=0.
- op_a, op_b, op_code hold between frames.
- A SOF byte arriving mid-frame is treated as data, not as a resync.
- Bytes arriving during EXEC through SEND_STS stay in the RX FIFO; they are not popped until IDLE.

Reset mid-operation:
- Immediate abort to the reset values.
- A partially sent response is not completed.
- RX FIFO contents are not touched by this block.

Test Plan:
1. Good ADD frame A5 05 03 20 26 (opcode 6'b100000 = ADD), tx_full=0 -> 5 rd_uart pulses; op_a=05, op_b=03, op_code=20; TX bytes 08 then 00; err_count=0; busy low afterwards.
2. Bad checksum A5 05 03 20 27 -> op regs unchanged from the prior frame; TX 00 then 01; err_count=1.
3. Garbage 11 22 A5 then a valid frame -> 11 and 22 popped and dropped with no error; response for the valid frame correct.
4. Timeout: A5 05, then no bytes for TIMEOUT cycles -> return to IDLE at exactly TIMEOUT cycles after the last pop; no wr_uart; err_count++. A following valid frame is then processed normally.
5. Backpressure: valid frame with tx_full=1 held for 20 cycles -> no wr_uart while full; result byte pushed on the first cycle after tx_full drops, status byte after it; no duplicate or lost byte.
6. Reset asserted during GET_B, and again during SEND_STS -> all outputs return to 0 asynchronously; the next frame after reset is decoded correctly. Also force 256+ errors -> err_count saturates at FF.
